i2c_slave_regfile: RTL and testbench

Synthesizable I2C slave with a parametrised register file. It is the RTL successor to the behavioural slave model paired with i2c_top in dut_top. It oversamples SCL/SDA on the core clock and decodes START/STOP and the 7-bit address. It supports a register-pointer write, burst write and burst read with auto-increment and wrap, and open-drain ACK/data drive. It drops into dut_top in place of the model and keeps the model's start/stop/data observation outputs.

---
 rtl/i2c_slave_regfile.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C slave (7-bit address) fronting a REG_DEPTH x DATA_SIZE register file: pointer write, burst write, burst read.
// Latency: 2-FF sync + edge detect; ACK/data drive changes ~3 core clocks after each SCL fall; start/stop pulse 1 cycle after detection.
// Backpressure: none on the core side; the bus master paces everything via SCL, the slave only ACKs/NACKs.
// Ports: i2c_core_clk_i/i2c_core_rst_i (sync, active-high); scl_io sampled only; sda_io open-drain (0 or z);
//        start/stop/data_slave_read/data_slave_read_valid/addr_match_o observation; reg_rd_addr_i/reg_rd_data_o backdoor read.
module i2c_slave_regfile #(
    parameter int         DATA_SIZE  = 8,
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         REG_DEPTH  = 16,
    parameter int         PTR_SIZE   = 4
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 i2c_core_rst_i,
    inout  wire                  scl_io,
    inout  wire                  sda_io,
    output logic                 start,
    output logic                 stop,
    output logic [DATA_SIZE-1:0] data_slave_read,
    output logic                 data_slave_read_valid,
    output logic                 addr_match_o,
    input  logic [PTR_SIZE-1:0]  reg_rd_addr_i,
    output logic [DATA_SIZE-1:0] reg_rd_data_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_e;

    // [0]=first sync stage, [1]=synced value, [2]=previous synced value
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_SIZE-1:0]   shift_q, shift_d;
    logic [PTR_SIZE-1:0]    ptr_q, ptr_d, ptr_inc;
    logic                   sda_oe_q, sda_oe_d;
    logic                   match_q, match_d;
    logic                   start_q, start_d;
    logic                   stop_q, stop_d;
    logic [DATA_SIZE-1:0]   rdata_q, rdata_d;
    logic                   rvld_q, rvld_d;
    logic [DATA_SIZE-1:0]   regs_q [REG_DEPTH];
    logic [DATA_SIZE-1:0]   regs_d [REG_DEPTH];

    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [DATA_SIZE-1:0]   rx_byte;

    assign scl_s    = scl_pipe_q[1];
    assign sda_s    = sda_pipe_q[1];
    assign scl_rise = ~scl_pipe_q[2] &  scl_s;
    assign scl_fall =  scl_pipe_q[2] & ~scl_s;
    // SCL must be high on both samples so an SDA edge is a bus condition, not data
    assign start_det = scl_s & scl_pipe_q[2] &  sda_pipe_q[2] & ~sda_s;
    assign stop_det  = scl_s & scl_pipe_q[2] & ~sda_pipe_q[2] &  sda_s;
    assign rx_byte   = {shift_q[DATA_SIZE-2:0], sda_s};
    assign ptr_inc   = (ptr_q == PTR_SIZE'(REG_DEPTH - 1)) ? '0 : ptr_q + PTR_SIZE'(1);

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_io};
        sda_pipe_d = {sda_pipe_q[1:0], sda_io};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        match_d    = match_q;
        rdata_d    = rdata_q;
        rvld_d     = 1'b0;
        regs_d     = regs_q;
        start_d    = start_det;
        stop_d     = stop_det;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            match_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            match_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = (rx_byte[DATA_SIZE-1:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT;
                end
                // ACK states: first fall drives the ACK (sda_oe was 0), second fall ends it.
                // shift_q[0] still holds the R/W bit of the address byte.
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                        match_d  = 1'b1;
                    end else if (shift_q[0]) begin
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][DATA_SIZE-1];
                        bit_cnt_d = '0;
                        state_d   = RDATA;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = PTR;
                    end
                end
                PTR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ptr_d   = ({1'b0, rx_byte} < (DATA_SIZE+1)'(REG_DEPTH)) ?
                                  rx_byte[PTR_SIZE-1:0] : '0;
                        state_d = PTR_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = WDATA;
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        regs_d[ptr_q] = rx_byte;
                        rdata_d       = rx_byte;
                        rvld_d        = 1'b1;
                        ptr_d         = ptr_inc;
                        state_d       = WDATA_ACK;
                    end
                end
                // MSB is already on the bus on entry; each fall advances one bit,
                // the 8th fall releases SDA for the master's ACK.
                RDATA: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = RDATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[DATA_SIZE-2:0], 1'b0};
                        sda_oe_d  = ~shift_q[DATA_SIZE-2];
                    end
                end
                // NACK leaves on the rise, so any fall seen here follows an ACK.
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = WAIT;
                        else       ptr_d   = ptr_inc;
                    end else if (scl_fall) begin
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][DATA_SIZE-1];
                        bit_cnt_d = '0;
                        state_d   = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            scl_pipe_q <= '0;
            sda_pipe_q <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            match_q    <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rdata_q    <= '0;
            rvld_q     <= 1'b0;
            regs_q     <= '{default: '0};
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            match_q    <= match_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            rdata_q    <= rdata_d;
            rvld_q     <= rvld_d;
            regs_q     <= regs_d;
        end
    end

    assign sda_io                = sda_oe_q ? 1'b0 : 1'bz;
    assign start                 = start_q;
    assign stop                  = stop_q;
    assign data_slave_read       = rdata_q;
    assign data_slave_read_valid = rvld_q;
    assign addr_match_o          = match_q;

    generate
        if (REG_DEPTH == (1 << PTR_SIZE)) begin : g_full
            assign reg_rd_data_o = regs_q[reg_rd_addr_i];
        end else begin : g_part
            assign reg_rd_data_o = ({1'b0, reg_rd_addr_i} < (PTR_SIZE+1)'(REG_DEPTH)) ?
                                   regs_q[reg_rd_addr_i] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master driving a table of bus
// operations and expected results, plus hand-written abort and reset sequences.
module tb_i2c_slave_regfile;

    localparam int Q = 8;  // core clocks per SCL quarter phase

    localparam logic [3:0] OP_START  = 4'd0;  // START or repeated START
    localparam logic [3:0] OP_STOP   = 4'd1;
    localparam logic [3:0] OP_WR     = 4'd2;  // write arg, exp = expected ACK
    localparam logic [3:0] OP_RD     = 4'd3;  // read, arg[0] = master ACK, exp = byte
    localparam logic [3:0] OP_REG    = 4'd4;  // backdoor read arg, exp = data
    localparam logic [3:0] OP_NSTART = 4'd5;  // exp = start pulses so far
    localparam logic [3:0] OP_NSTOP  = 4'd6;
    localparam logic [3:0] OP_NVLD   = 4'd7;
    localparam logic [3:0] OP_VDAT   = 4'd8;  // arg = index of valid pulse, exp = data
    localparam logic [3:0] OP_MATCH  = 4'd9;
    localparam logic [3:0] OP_SDA    = 4'd10; // exp = sampled SDA level

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] arg;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_low = 1'b0;
    logic [3:0] rd_addr = '0;
    wire        scl_w;
    wire        sda_w;
    logic       start, stop, dvld, match;
    logic [7:0] dread, rdata;

    assign scl_w = scl_drv;
    assign sda_w = sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave_regfile dut (
        .i2c_core_clk_i        (clk),
        .i2c_core_rst_i        (rst),
        .scl_io                (scl_w),
        .sda_io                (sda_w),
        .start                 (start),
        .stop                  (stop),
        .data_slave_read       (dread),
        .data_slave_read_valid (dvld),
        .addr_match_o          (match),
        .reg_rd_addr_i         (rd_addr),
        .reg_rd_data_o         (rdata)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         n_start = 0;
    int         n_stop = 0;
    logic [7:0] vld_q[$];
    vec_t       tbl[$];

    always @(negedge clk) begin
        if (start) n_start++;
        if (stop)  n_stop++;
        if (dvld)  vld_q.push_back(dread);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] op, input logic [7:0] arg, input logic [7:0] exp);
        vec_t v;
        v.op = op; v.arg = arg; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Works from bus idle and as a repeated START with SCL low.
    task automatic bus_start();
        sda_low = 1'b0; wq(Q);
        scl_drv = 1'b1; wq(Q);
        sda_low = 1'b1; wq(Q);
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic bus_stop();
        scl_drv = 1'b0;
        sda_low = 1'b1; wq(Q);
        scl_drv = 1'b1; wq(Q);
        sda_low = 1'b0; wq(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b;   wq(Q);
        scl_drv = 1'b1; wq(Q);
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_low = 1'b0; wq(Q);
        scl_drv = 1'b1; wq(Q);
        ack = ~sda_w;
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            sda_low = 1'b0; wq(Q);
            scl_drv = 1'b1; wq(Q);
            b = {b[6:0], sda_w};
            scl_drv = 1'b0; wq(Q);
        end
        sda_low = send_ack; wq(Q);
        scl_drv = 1'b1;     wq(Q);
        scl_drv = 1'b0;
        sda_low = 1'b0;     wq(Q);
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        vec_t       v;

        // ---- burst write ----
        add(OP_START, 0, 0);
        add(OP_WR, 8'h78, 1); add(OP_WR, 8'h02, 1); add(OP_WR, 8'hA5, 1);
        add(OP_MATCH, 0, 1);
        add(OP_WR, 8'h5A, 1);
        add(OP_STOP, 0, 0);
        add(OP_REG, 8'h02, 8'hA5); add(OP_REG, 8'h03, 8'h5A);
        add(OP_NSTART, 0, 1); add(OP_NSTOP, 0, 1); add(OP_NVLD, 0, 2);
        add(OP_VDAT, 0, 8'hA5); add(OP_VDAT, 1, 8'h5A); add(OP_MATCH, 0, 0);
        // ---- address miss ----
        add(OP_START, 0, 0);
        add(OP_WR, 8'hA0, 0); add(OP_MATCH, 0, 0); add(OP_WR, 8'h11, 0);
        add(OP_STOP, 0, 0);
        add(OP_REG, 8'h02, 8'hA5); add(OP_REG, 8'h01, 8'h00);
        add(OP_NVLD, 0, 2); add(OP_NSTART, 0, 2); add(OP_NSTOP, 0, 2);
        // ---- repeated-start read ----
        add(OP_START, 0, 0);
        add(OP_WR, 8'h78, 1); add(OP_WR, 8'h02, 1);
        add(OP_START, 0, 0);
        add(OP_WR, 8'h79, 1); add(OP_MATCH, 0, 1);
        add(OP_RD, 1, 8'hA5); add(OP_RD, 0, 8'h5A);
        add(OP_SDA, 0, 1); add(OP_MATCH, 0, 1);
        add(OP_STOP, 0, 0);
        add(OP_NSTART, 0, 4); add(OP_NSTOP, 0, 3); add(OP_NVLD, 0, 2); add(OP_MATCH, 0, 0);
        // ---- pointer wrap ----
        add(OP_START, 0, 0);
        add(OP_WR, 8'h78, 1); add(OP_WR, 8'h0F, 1); add(OP_WR, 8'h11, 1); add(OP_WR, 8'h22, 1);
        add(OP_STOP, 0, 0);
        add(OP_REG, 8'h0F, 8'h11); add(OP_REG, 8'h00, 8'h22);
        add(OP_NVLD, 0, 4); add(OP_VDAT, 2, 8'h11); add(OP_VDAT, 3, 8'h22);
        // ---- out-of-range pointer byte maps to 0 ----
        add(OP_START, 0, 0);
        add(OP_WR, 8'h78, 1); add(OP_WR, 8'h20, 1); add(OP_WR, 8'h33, 1);
        add(OP_STOP, 0, 0);
        add(OP_REG, 8'h00, 8'h33); add(OP_REG, 8'h01, 8'h00);
        add(OP_NVLD, 0, 5); add(OP_VDAT, 4, 8'h33);

        // ---- reset state ----
        wq(3);
        chk("rst_start", int'(start), 0);
        chk("rst_stop", int'(stop), 0);
        chk("rst_dread", int'(dread), 0);
        chk("rst_dvld", int'(dvld), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_sda", int'(sda_w), 1);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            chk($sformatf("rst_reg%0d", a), int'(rdata), 0);
        end
        rst = 1'b0;
        wq(4);

        // ---- table ----
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            case (v.op)
                OP_START: bus_start();
                OP_STOP:  bus_stop();
                OP_WR: begin
                    write_byte(v.arg, ack);
                    chk($sformatf("v%0d_ack_%02h", i, v.arg), int'(ack), int'(v.exp));
                end
                OP_RD: begin
                    read_byte(v.arg[0], b);
                    chk($sformatf("v%0d_rd", i), int'(b), int'(v.exp));
                end
                OP_REG: begin
                    rd_addr = v.arg[3:0]; #1;
                    chk($sformatf("v%0d_reg%0d", i, v.arg), int'(rdata), int'(v.exp));
                end
                OP_NSTART: chk($sformatf("v%0d_nstart", i), n_start, int'(v.exp));
                OP_NSTOP:  chk($sformatf("v%0d_nstop", i), n_stop, int'(v.exp));
                OP_NVLD:   chk($sformatf("v%0d_nvld", i), vld_q.size(), int'(v.exp));
                OP_VDAT:   chk($sformatf("v%0d_vdat%0d", i, v.arg),
                               (int'(v.arg) < vld_q.size()) ? int'(vld_q[v.arg]) : -1, int'(v.exp));
                OP_MATCH:  chk($sformatf("v%0d_match", i), int'(match), int'(v.exp));
                OP_SDA:    chk($sformatf("v%0d_sda", i), int'(sda_w), int'(v.exp));
                default: ;
            endcase
        end

        // ---- abort: STOP after 4 data bits writes nothing, pointer stays put ----
        bus_start();
        write_byte(8'h78, ack); chk("ab_addr_ack", int'(ack), 1);
        write_byte(8'h0F, ack); chk("ab_ptr_ack", int'(ack), 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        rd_addr = 4'hF; #1;
        chk("ab_reg15", int'(rdata), 8'h11);
        chk("ab_nvld", vld_q.size(), 5);
        chk("ab_match", int'(match), 0);
        bus_start();
        write_byte(8'h79, ack); chk("ab_rd_ack", int'(ack), 1);
        read_byte(1'b0, b);     chk("ab_rd_ptr15", int'(b), 8'h11);
        bus_stop();

        // ---- reset while slave drives a 0 data bit ----
        bus_start();
        write_byte(8'h78, ack); write_byte(8'h00, ack);
        bus_start();
        write_byte(8'h79, ack); chk("rr_ack", int'(ack), 1);
        chk("rr_sda_driven", int'(sda_w), 0);
        rst = 1'b1;
        chk("rr_sda_pre_edge", int'(sda_w), 0);
        wq(1);
        chk("rr_sda_released", int'(sda_w), 1);
        chk("rr_match", int'(match), 0);
        wq(2);
        rst = 1'b0;
        wq(1);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            chk($sformatf("rr_reg%0d", a), int'(rdata), 0);
        end
        chk("rr_dread", int'(dread), 0);
        bus_stop();

        // ---- slave still functional after reset ----
        bus_start();
        write_byte(8'h78, ack); chk("pr_addr_ack", int'(ack), 1);
        write_byte(8'h04, ack); chk("pr_ptr_ack", int'(ack), 1);
        write_byte(8'hC3, ack); chk("pr_data_ack", int'(ack), 1);
        bus_stop();
        rd_addr = 4'h4; #1;
        chk("pr_reg4", int'(rdata), 8'hC3);
        chk("pr_dread", int'(dread), 8'hC3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
